// File: rtl/pulse_param_loader.sv
// pulse_param_loader: frames, checks and publishes the pulse-parameter set
// received as a UART byte stream. Ports: clk, reset (async, active high),
// rx_data/rx_valid (byte stream in), pulse-parameter outputs (pu, per,
// p1wid, del, p2wid, nut_w, nut_d, nut, cp, p_bl, p_bl_off, bl),
// load_stb / frame_err (one-cycle pulses), err_count (saturating), busy.
module pulse_param_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [19:0] TIMEOUT   = 20'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        pu,
    output logic [7:0]  per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic [31:0] nut_w,
    output logic [31:0] nut_d,
    output logic        nut,
    output logic [7:0]  cp,
    output logic [7:0]  p_bl,
    output logic [15:0] p_bl_off,
    output logic        bl,
    output logic        load_stb,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_idx;
    logic [7:0]  r_sum;
    logic [19:0] r_gap;

    logic        w_start;
    logic        w_take;
    logic        w_load;
    logic        w_err;
    logic        w_tmo;

    // Staging copy of the parameter set, filled byte by byte
    logic        r_s_pu;
    logic [7:0]  r_s_per;
    logic [15:0] r_s_p1wid;
    logic [15:0] r_s_del;
    logic [15:0] r_s_p2wid;
    logic [31:0] r_s_nut_w;
    logic [31:0] r_s_nut_d;
    logic        r_s_nut;
    logic [7:0]  r_s_cp;
    logic [7:0]  r_s_p_bl;
    logic [15:0] r_s_p_bl_off;
    logic        r_s_bl;

    // Published copy, only ever updated as a whole
    logic        r_pu;
    logic [7:0]  r_per;
    logic [15:0] r_p1wid;
    logic [15:0] r_del;
    logic [15:0] r_p2wid;
    logic [31:0] r_nut_w;
    logic [31:0] r_nut_d;
    logic        r_nut;
    logic [7:0]  r_cp;
    logic [7:0]  r_p_bl;
    logic [15:0] r_p_bl_off;
    logic        r_bl;

    logic        r_load_stb;
    logic        r_frame_err;
    logic [7:0]  r_err_count;

    // A byte arriving in the same cycle always takes priority over timeout
    assign w_tmo = (r_gap == TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_take  = 1'b0;
        w_load  = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_next  = S_PAYLOAD;
                    w_start = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    w_take = 1'b1;
                    if (r_idx == 5'd21) begin
                        w_next = S_CHECK;
                    end
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                    w_err  = 1'b1;
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    w_next = S_IDLE;
                    if (rx_data == r_sum) begin
                        w_load = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                    w_err  = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: index, running sum, inter-byte gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 5'd0;
            r_sum <= 8'd0;
            r_gap <= 20'd0;
        end else begin
            if (w_start) begin
                r_idx <= 5'd0;
                r_sum <= 8'd0;
            end else if (w_take) begin
                r_idx <= r_idx + 5'd1;
                r_sum <= r_sum + rx_data;
            end
            if ((r_state == S_IDLE) || rx_valid) begin
                r_gap <= 20'd0;
            end else begin
                r_gap <= r_gap + 20'd1;
            end
        end
    end

    // Staging writes; multi-byte fields arrive MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_pu       <= 1'b0;
            r_s_per      <= 8'd0;
            r_s_p1wid    <= 16'd0;
            r_s_del      <= 16'd0;
            r_s_p2wid    <= 16'd0;
            r_s_nut_w    <= 32'd0;
            r_s_nut_d    <= 32'd0;
            r_s_nut      <= 1'b0;
            r_s_cp       <= 8'd0;
            r_s_p_bl     <= 8'd0;
            r_s_p_bl_off <= 16'd0;
            r_s_bl       <= 1'b0;
        end else if (w_take) begin
            case (r_idx)
                5'd0:  r_s_pu              <= rx_data[0];
                5'd1:  r_s_per             <= rx_data;
                5'd2:  r_s_p1wid[15:8]     <= rx_data;
                5'd3:  r_s_p1wid[7:0]      <= rx_data;
                5'd4:  r_s_del[15:8]       <= rx_data;
                5'd5:  r_s_del[7:0]        <= rx_data;
                5'd6:  r_s_p2wid[15:8]     <= rx_data;
                5'd7:  r_s_p2wid[7:0]      <= rx_data;
                5'd8:  r_s_nut_w[31:24]    <= rx_data;
                5'd9:  r_s_nut_w[23:16]    <= rx_data;
                5'd10: r_s_nut_w[15:8]     <= rx_data;
                5'd11: r_s_nut_w[7:0]      <= rx_data;
                5'd12: r_s_nut_d[31:24]    <= rx_data;
                5'd13: r_s_nut_d[23:16]    <= rx_data;
                5'd14: r_s_nut_d[15:8]     <= rx_data;
                5'd15: r_s_nut_d[7:0]      <= rx_data;
                5'd16: r_s_nut             <= rx_data[0];
                5'd17: r_s_cp              <= rx_data;
                5'd18: r_s_p_bl            <= rx_data;
                5'd19: r_s_p_bl_off[15:8]  <= rx_data;
                5'd20: r_s_p_bl_off[7:0]   <= rx_data;
                5'd21: r_s_bl              <= rx_data[0];
                default: ;
            endcase
        end
    end

    // Atomic publish on a good checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pu       <= 1'b1;
            r_per      <= 8'd1;
            r_p1wid    <= 16'd30;
            r_del      <= 16'd200;
            r_p2wid    <= 16'd30;
            r_nut_w    <= 32'd50;
            r_nut_d    <= 32'd300;
            r_nut      <= 1'b1;
            r_cp       <= 8'd3;
            r_p_bl     <= 8'd50;
            r_p_bl_off <= 16'd100;
            r_bl       <= 1'b1;
        end else if (w_load) begin
            r_pu       <= r_s_pu;
            r_per      <= r_s_per;
            r_p1wid    <= r_s_p1wid;
            r_del      <= r_s_del;
            r_p2wid    <= r_s_p2wid;
            r_nut_w    <= r_s_nut_w;
            r_nut_d    <= r_s_nut_d;
            r_nut      <= r_s_nut;
            r_cp       <= r_s_cp;
            r_p_bl     <= r_s_p_bl;
            r_p_bl_off <= r_s_p_bl_off;
            r_bl       <= r_s_bl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_stb  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_load_stb  <= w_load;
            r_frame_err <= w_err;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign pu        = r_pu;
    assign per       = r_per;
    assign p1wid     = r_p1wid;
    assign del       = r_del;
    assign p2wid     = r_p2wid;
    assign nut_w     = r_nut_w;
    assign nut_d     = r_nut_d;
    assign nut       = r_nut;
    assign cp        = r_cp;
    assign p_bl      = r_p_bl;
    assign p_bl_off  = r_p_bl_off;
    assign bl        = r_bl;
    assign load_stb  = r_load_stb;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pulse_param_loader.sv
// Testbench for pulse_param_loader: scoreboard of expected load/error
// events, popped whenever the DUT pulses load_stb or frame_err.
module tb_pulse_param_loader;

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [19:0] TMO  = 20'd200;
    localparam logic [154:0] DEF = {1'b1, 8'd1, 16'd30, 16'd200, 16'd30,
        32'd50, 32'd300, 1'b1, 8'd3, 8'd50, 16'd100, 1'b1};

    typedef logic [7:0] pay_t [22];
    typedef struct {
        bit           is_load;
        logic [154:0] outs;
        logic [7:0]   errc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        pu, nut, bl, load_stb, frame_err, busy;
    logic [7:0]  per, cp, p_bl, err_count;
    logic [15:0] p1wid, del, p2wid, p_bl_off;
    logic [31:0] nut_w, nut_d;
    logic [154:0] outs;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];
    exp_t m_e;
    logic [154:0] cur = DEF;
    logic [7:0]   exp_err = 8'd0;

    always #5 clk = ~clk;

    assign outs = {pu, per, p1wid, del, p2wid, nut_w, nut_d, nut, cp,
        p_bl, p_bl_off, bl};

    pulse_param_loader #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .pu(pu),
        .per(per),
        .p1wid(p1wid),
        .del(del),
        .p2wid(p2wid),
        .nut_w(nut_w),
        .nut_d(nut_d),
        .nut(nut),
        .cp(cp),
        .p_bl(p_bl),
        .p_bl_off(p_bl_off),
        .bl(bl),
        .load_stb(load_stb),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy(busy)
    );

    // Scoreboard consumer
    always @(negedge clk) begin
        if (load_stb || frame_err) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: load_stb=%b frame_err=%b required none",
                    load_stb, frame_err);
            end else begin
                m_e = q.pop_front();
                if ({load_stb, frame_err, outs, err_count} !==
                    {m_e.is_load, !m_e.is_load, m_e.outs, m_e.errc}) begin
                    n_bad++;
                    $display("FAIL event: got ld=%b er=%b outs=%h ec=%0d need ld=%b outs=%h ec=%0d",
                        load_stb, frame_err, outs, err_count,
                        m_e.is_load, m_e.outs, m_e.errc);
                end
            end
        end
    end

    function automatic logic [154:0] parse(input pay_t p);
        return {p[0][0], p[1], p[2], p[3], p[4], p[5], p[6], p[7],
            p[8], p[9], p[10], p[11], p[12], p[13], p[14], p[15],
            p[16][0], p[17], p[18], p[19], p[20], p[21][0]};
    endfunction

    function automatic logic [7:0] csum(input pay_t p);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < 22; i++) s = s + p[i];
        return s;
    endfunction

    function automatic pay_t rnd_pay();
        pay_t p;
        for (int i = 0; i < 22; i++) p[i] = 8'($urandom);
        return p;
    endfunction

    function automatic pay_t plan_pay();
        pay_t p = '{8'h00, 8'h02, 8'h00, 8'h28, 8'h01, 8'h2C, 8'h00,
            8'h28, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h01,
            8'hF4, 8'h00, 8'h05, 8'h32, 8'h00, 8'hC8, 8'h01};
        return p;
    endfunction

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'd0;
        end
    endtask

    task automatic send_frame(input pay_t p, input logic [7:0] chk);
        put(SYNC);
        for (int i = 0; i < 22; i++) put(p[i]);
        put(chk);
    endtask

    task automatic push_load(input pay_t p);
        exp_t e;
        cur = parse(p);
        e.is_load = 1'b1;
        e.outs = cur;
        e.errc = exp_err;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        e.is_load = 1'b0;
        e.outs = cur;
        e.errc = exp_err;
        q.push_back(e);
    endtask

    task automatic wait_q(input int budget, output bit ok);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        ok = (q.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({outs, load_stb, frame_err, err_count, busy} !==
            {DEF, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got %h ld=%b er=%b ec=%0d bsy=%b need %h 0 0 0 0",
                outs, load_stb, frame_err, err_count, busy, DEF);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_bad_checksum();
        bit ok;
        push_err();
        send_frame(plan_pay(), 8'h8C);
        idle(1);
        wait_q(40, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bad_cksum_wait: pending=%0d required 0", q.size());
            q.delete();
        end
        n_cmp++;
        if ({outs, err_count, busy} !== {DEF, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL bad_cksum_state: outs=%h ec=%0d bsy=%b need %h 1 0",
                outs, err_count, busy, DEF);
        end
    endtask

    task automatic test_valid_frame();
        bit ok;
        pay_t p = plan_pay();
        push_load(p);
        send_frame(p, csum(p));
        idle(1);
        wait_q(40, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL valid_wait: pending=%0d required 0", q.size());
            q.delete();
        end
        n_cmp++;
        if ({pu, per, p1wid, del, p2wid, nut_w, nut_d, nut, cp, p_bl,
             p_bl_off, bl} !== {1'b0, 8'd2, 16'd40, 16'd300, 16'd40,
             32'd100, 32'd500, 1'b0, 8'd5, 8'd50, 16'd200, 1'b1}) begin
            n_bad++;
            $display("FAIL valid_fields: got %h", outs);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        pay_t p = rnd_pay();
        put(SYNC);
        for (int i = 0; i < 10; i++) put(p[i]);
        push_err();
        idle(2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_busy_mid: got %b required 1", busy);
        end
        wait_q(int'(TMO) + 40, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout_wait: pending=%0d required 0", q.size());
            q.delete();
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_busy_end: got %b required 0", busy);
        end
        p = rnd_pay();
        push_load(p);
        send_frame(p, csum(p));
        idle(1);
        wait_q(40, ok);
        n_cmp++;
        if (!ok || outs !== parse(p)) begin
            n_bad++;
            $display("FAIL timeout_reload: outs=%h need %h", outs, parse(p));
            q.delete();
        end
    endtask

    task automatic test_junk_sync();
        bit ok;
        pay_t p = plan_pay();
        p[1] = SYNC;
        p[2] = SYNC;
        p[3] = SYNC;
        p[17] = SYNC;
        p[18] = SYNC;
        put(8'h00);
        put(8'hFF);
        put(8'h3C);
        push_load(p);
        send_frame(p, csum(p));
        idle(1);
        wait_q(40, ok);
        n_cmp++;
        if (!ok || {per, p1wid, cp, p_bl} !== {8'hA5, 16'hA5A5, 8'hA5, 8'hA5}) begin
            n_bad++;
            $display("FAIL junk_sync: per=%h p1wid=%h cp=%h p_bl=%h need a5 a5a5 a5 a5",
                per, p1wid, cp, p_bl);
            q.delete();
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        pay_t p = plan_pay();
        put(SYNC);
        for (int i = 0; i < 12; i++) put(p[i]);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({outs, load_stb, frame_err, err_count, busy} !==
            {DEF, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL midframe_reset: outs=%h ld=%b er=%b ec=%0d bsy=%b need %h 0 0 0 0",
                outs, load_stb, frame_err, err_count, busy, DEF);
        end
        cur = DEF;
        exp_err = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 12; i < 22; i++) put(p[i]);
        put(csum(p));
        idle(5);
        n_cmp++;
        if ({outs, busy} !== {DEF, 1'b0}) begin
            n_bad++;
            $display("FAIL midframe_tail: outs=%h bsy=%b need %h 0", outs, busy, DEF);
        end
        push_load(p);
        send_frame(p, csum(p));
        idle(1);
        wait_q(40, ok);
        n_cmp++;
        if (!ok || outs !== parse(p)) begin
            n_bad++;
            $display("FAIL midframe_resend: outs=%h need %h", outs, parse(p));
            q.delete();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        pay_t a = rnd_pay();
        pay_t b = rnd_pay();
        push_load(a);
        push_load(b);
        send_frame(a, csum(a));
        send_frame(b, csum(b));
        idle(1);
        wait_q(80, ok);
        n_cmp++;
        if (!ok || outs !== parse(b)) begin
            n_bad++;
            $display("FAIL back_to_back: outs=%h need %h pending=%0d",
                outs, parse(b), q.size());
            q.delete();
        end
    endtask

    task automatic test_saturation();
        bit ok;
        pay_t p;
        for (int k = 0; k < 300; k++) begin
            p = rnd_pay();
            push_err();
            send_frame(p, csum(p) + 8'd1);
        end
        idle(1);
        wait_q(60, ok);
        n_cmp++;
        if (!ok || err_count !== 8'd255 || outs !== cur) begin
            n_bad++;
            $display("FAIL saturation: ec=%0d need 255 outs=%h need %h",
                err_count, outs, cur);
            q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bad_checksum();
        test_valid_frame();
        test_timeout();
        test_junk_sync();
        test_reset_midframe();
        test_back_to_back();
        test_saturation();
        idle(5);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events: pending=%0d required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
